// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit divider scheduler.
package mdu_pkg;

  localparam int               DIV_W      = 32;
  localparam logic [DIV_W-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [DIV_W-1:0] INT_MIN    = 32'h8000_0000;

  // The core is busy for 32 cycles; the WAIT timer counts 31 down to 0 so that
  // FIX lands on the first cycle the core results are valid.
  localparam logic [4:0] WAIT_TC_LOAD = 5'd31;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    FIX,
    RESP
  } state_e;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation: magnitude of a signed operand, or sign
// restoration of an unsigned core result.
module div_sign_fix
  import mdu_pkg::*;
(
  input  logic [DIV_W-1:0] val_i,
  input  logic             neg_i,
  output logic [DIV_W-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + DIV_W'(1)) : val_i;

endmodule

// File: rtl/div_sched.sv
// Round-robin scheduler for two requesters sharing one 32-bit iterative divider.
// state | meaning
// IDLE  | offer grant, accept one request, resolve div-by-zero / overflow directly
// ISSUE | one-cycle core_start with magnitude operands
// WAIT  | core iterating, down-counter tracks the 32 busy cycles
// FIX   | restore quotient/remainder signs from core results
// RESP  | hold result until resp_ready
module div_sched
  import mdu_pkg::*;
(
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  logic [1:0]       req_signed_i,
  input  logic [DIV_W-1:0] req_dividend0_i,
  input  logic [DIV_W-1:0] req_dividend1_i,
  input  logic [DIV_W-1:0] req_divisor0_i,
  input  logic [DIV_W-1:0] req_divisor1_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic             resp_id_o,
  output logic [DIV_W-1:0] resp_q_o,
  output logic [DIV_W-1:0] resp_r_o,
  output logic             core_start_o,
  output logic [DIV_W-1:0] core_dividend_o,
  output logic [DIV_W-1:0] core_divisor_o,
  input  logic             core_busy_i,
  input  logic [DIV_W-1:0] core_q_i,
  input  logic [DIV_W-1:0] core_r_i
);

  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic             id_q, id_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [DIV_W-1:0] a_q, a_d, b_q, b_d;
  logic [DIV_W-1:0] q_q, q_d, r_q, r_d;
  logic [4:0]       tmr_q, tmr_d;

  logic             gnt_id, accept, sel_sgn, div_zero, ovf;
  logic [DIV_W-1:0] sel_dvd, sel_dvs, mag_dvd, mag_dvs, fix_q, fix_r;

  // rr_q names the requester preferred when both are valid
  always_comb begin
    gnt_id = 1'b0;
    case (req_valid_i)
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = rr_q;
      default: gnt_id = 1'b0;
    endcase
  end

  assign accept   = reset_ni && (state_q == IDLE) && (|req_valid_i);
  assign sel_dvd  = gnt_id ? req_dividend1_i : req_dividend0_i;
  assign sel_dvs  = gnt_id ? req_divisor1_i : req_divisor0_i;
  assign sel_sgn  = req_signed_i[gnt_id];
  assign div_zero = (sel_dvs == '0);
  assign ovf      = sel_sgn && (sel_dvd == INT_MIN) && (sel_dvs == '1);

  div_sign_fix u_mag_dvd (.val_i(sel_dvd),  .neg_i(sel_sgn & sel_dvd[DIV_W-1]), .val_o(mag_dvd));
  div_sign_fix u_mag_dvs (.val_i(sel_dvs),  .neg_i(sel_sgn & sel_dvs[DIV_W-1]), .val_o(mag_dvs));
  div_sign_fix u_fix_q   (.val_i(core_q_i), .neg_i(q_neg_q),                    .val_o(fix_q));
  div_sign_fix u_fix_r   (.val_i(core_r_i), .neg_i(r_neg_q),                    .val_o(fix_r));

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      id_q    <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    a_d     = a_q;
    b_d     = b_q;
    q_d     = q_q;
    r_d     = r_q;
    tmr_d   = tmr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rr_d = ~gnt_id;
          id_d = gnt_id;
          if (div_zero) begin
            q_d     = DIV_ZERO_Q;
            r_d     = sel_dvd;
            state_d = RESP;
          end else if (ovf) begin
            q_d     = INT_MIN;
            r_d     = '0;
            state_d = RESP;
          end else begin
            a_d     = mag_dvd;
            b_d     = mag_dvs;
            q_neg_d = sel_sgn & (sel_dvd[DIV_W-1] ^ sel_dvs[DIV_W-1]);
            r_neg_d = sel_sgn & sel_dvd[DIV_W-1];
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        tmr_d   = WAIT_TC_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        // early busy drop is honoured as well as the terminal count
        if ((tmr_q == '0) || !core_busy_i) begin
          state_d = FIX;
        end else begin
          tmr_d = tmr_q - 5'd1;
        end
      end
      FIX: begin
        q_d     = fix_q;
        r_d     = fix_r;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready_o     = accept ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
  assign core_start_o    = reset_ni && (state_q == ISSUE);
  assign resp_valid_o    = reset_ni && (state_q == RESP);
  assign resp_id_o       = id_q;
  assign resp_q_o        = q_q;
  assign resp_r_o        = r_q;
  assign core_dividend_o = a_q;
  assign core_divisor_o  = b_q;

endmodule
